pueo_scaler_gate_counter: RTL and testbench
===========================================

PUEO_SCALER_GATE_COUNTER -- requirements
Module: pueo_scaler_gate_counter

Interface
REQ-001 SHALL have parameter NCHAN, default 8, number of scaler channels (1..16).
REQ-002 SHALL have parameter NGP, default 6, number of general-purpose gate inputs (1..8).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, scaler counter width (8..32).
REQ-004 SHALL have parameter GATELEN_WIDTH, default 16, PPS window length width (1..16).
REQ-005 SHALL use one clock and a synchronous, active-high reset: wb_clk_i  in  1  sole clock; wb_rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL provide the Wishbone target ports wb_cyc_i, wb_stb_i, wb_we_i (in, 1), wb_adr_i (in, 7, byte address), wb_dat_i (in, 32), wb_sel_i (in, 4, ignored), wb_dat_o (out, 32), wb_ack_o, wb_err_o, wb_rty_o (out, 1).
REQ-007 SHALL provide pps_i  in  1  one-cycle PPS strobe, already synchronous.
REQ-008 SHALL provide gp_gate_i  in  NGP  general-purpose gate levels, already synchronous.
REQ-009 SHALL provide trig_i  in  NCHAN  per-channel trigger levels, one count per high cycle.
REQ-010 SHALL provide gate_o  out  1  the registered selected gate, and gate_en_o  out  NCHAN  the channel enable mask.

Function
REQ-011 SHALL map registers: 0x00 CTRL (RW: [3:0] gate_sel, [4] invert, [31:16] gatelen); 0x04 ENABLE (RW: [NCHAN-1:0]); 0x08 STATUS (RO: [NCHAN-1:0] saturated flags, [31] new_data); 0x40+4*i SCALER i (RO, zero-extended).
REQ-012 SHALL decode wb_adr_i[6:2]; reads of unmapped or unused bits SHALL return 0; writes to RO or unmapped addresses SHALL be ignored but acknowledged.
REQ-013 SHALL assert wb_ack_o for exactly one cycle, on the cycle after wb_cyc_i&&wb_stb_i is sampled with wb_ack_o low; wb_dat_o SHALL be valid with ack; no ack SHALL be issued while wb_cyc_i is low.
REQ-014 SHALL tie wb_err_o and wb_rty_o to 0.
REQ-015 SHALL register gp_gate_i once before use.
REQ-016 SHALL select the raw gate by gate_sel: 0 -> 0; 1..NGP -> registered gp_gate_i[gate_sel-1]; NGP+1 -> PPS window; NGP+2 -> 1; others -> 0.
REQ-017 SHALL compute gate_o one cycle after selection as (raw gate XOR invert); invert SHALL also apply to gate_sel 0 and out-of-range values.
REQ-018 SHALL open the PPS window on the cycle after pps_i when gate_sel==NGP+1 and hold it high for exactly gatelen+1 cycles; pps_i while the window is open SHALL be ignored (no retrigger).
REQ-019 SHALL, when gate_sel changes away from NGP+1, close the PPS window immediately and clear its counter.
REQ-020 SHALL increment counter i in any cycle where trig_i[i] && gate_o && ENABLE[i]; gate_o is sampled, not raw gate.
REQ-021 SHALL saturate each counter at 2^CNT_WIDTH-1 and set an internal saturated bit for that channel.
REQ-022 SHALL, on each pps_i cycle, copy every counter to SCALER i and its saturated bit to STATUS, set new_data, then load each counter with that cycle's increment (0 or 1) and clear its saturated bit.
REQ-023 SHALL clear new_data on an acknowledged read of STATUS; if pps_i coincides with that read, new_data SHALL remain set and the read SHALL return the pre-latch STATUS.
REQ-024 SHALL apply a CTRL or ENABLE write on the ack cycle; a gate_o or counting change SHALL take effect on the following cycle.
REQ-025 SHALL return CTRL and ENABLE readback exactly as last written, truncated to implemented bits.

Reset
REQ-026 SHALL, on wb_rst_i, clear all registers, counters, SCALER values, STATUS, PPS window, gate_o, gate_en_o and wb_ack_o to 0 on the next edge.
REQ-027 SHALL abort any in-flight Wishbone cycle on reset without issuing an ack.

Verification
REQ-028 SHALL cover: CTRL=0x0000_0002, ENABLE=0x01, gp_gate_i[1]=1, trig_i[0] high 100 cycles, then pps_i -> SCALER0=100, STATUS=0x8000_0000.
REQ-029 SHALL cover: gate_sel=NGP+1, gatelen=9, trig_i all-ones, ENABLE=0xFF, pps_i -> gate_o high exactly 10 cycles; at the next pps_i all SCALERs=10; a mid-window pps_i causes no extension.
REQ-030 SHALL cover: CNT_WIDTH=8, gate_sel=NGP+2, trig_i[3] high 300 cycles, then pps_i -> SCALER3=255, STATUS[3]=1; the following period has STATUS[3]=0.
REQ-031 SHALL cover: a STATUS read coincident with pps_i -> read returns prior STATUS and new_data stays 1; the next STATUS read returns new_data=1 and then clears it.
REQ-032 SHALL cover: invert=1 with gate_sel=0 -> gate_o=1 after 2 cycles; an unmapped read at 0x20 -> 0 with a single ack; wb_rst_i mid-cycle -> no ack and all outputs 0.

Source files
------------

// File: rtl/pueo_scaler_gate_counter.sv
// PUEO scaler gate counter: gated per-channel trigger scalers latched on PPS,
// with a Wishbone register file for gate control and readback.
module pueo_scaler_gate_counter #(
  parameter int NCHAN         = 8,
  parameter int NGP           = 6,
  parameter int CNT_WIDTH     = 16,
  parameter int GATELEN_WIDTH = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [6:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic             pps_i,
  input  logic [NGP-1:0]   gp_gate_i,
  input  logic [NCHAN-1:0] trig_i,
  output logic             gate_o,
  output logic [NCHAN-1:0] gate_en_o
);

  localparam logic [3:0] SEL_PPS = 4'(NGP + 1);
  localparam logic [3:0] SEL_ONE = 4'(NGP + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [GATELEN_WIDTH-1:0] glen_t;

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         gate_sel_q, gate_sel_d;
  logic               invert_q, invert_d;
  glen_t              gatelen_q, gatelen_d;
  logic [NCHAN-1:0]   enable_q, enable_d;
  logic               new_data_q, new_data_d;
  logic [NCHAN-1:0]   stat_sat_q, stat_sat_d;
  logic [NGP-1:0]     gp_q, gp_d;
  logic               win_q, win_d;
  glen_t              win_cnt_q, win_cnt_d;
  logic               gate_q, gate_d;
  cnt_t               cnt_q [NCHAN];
  cnt_t               cnt_d [NCHAN];
  cnt_t               scaler_q [NCHAN];
  cnt_t               scaler_d [NCHAN];
  logic [NCHAN-1:0]   sat_q, sat_d;

  logic               req, wr, rd;
  logic [4:0]         reg_idx;
  logic               is_scaler;
  cnt_t               scaler_rd;
  logic [31:0]        rdata;
  logic               raw_gate;
  logic [NCHAN-1:0]   inc;
  logic               unused;

  assign unused = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

  assign req       = wb_cyc_i && wb_stb_i && !ack_q;
  assign wr        = req && wb_we_i;
  assign rd        = req && !wb_we_i;
  assign reg_idx   = wb_adr_i[6:2];
  assign is_scaler = reg_idx[4] && (int'(reg_idx[3:0]) < NCHAN);
  assign inc       = trig_i & enable_q & {NCHAN{gate_q}};

  always_comb begin
    scaler_rd = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (reg_idx[3:0] == 4'(i)) scaler_rd = scaler_q[i];
    end
    rdata = '0;
    unique case (1'b1)
      reg_idx == 5'd0: begin
        rdata[3:0] = gate_sel_q;
        rdata[4]   = invert_q;
        rdata[16 +: GATELEN_WIDTH] = gatelen_q;
      end
      reg_idx == 5'd1: rdata[NCHAN-1:0] = enable_q;
      reg_idx == 5'd2: begin
        rdata[NCHAN-1:0] = stat_sat_q;
        rdata[31]        = new_data_q;
      end
      is_scaler: rdata[CNT_WIDTH-1:0] = scaler_rd;
      default: ;
    endcase
  end

  always_comb begin
    ack_d      = req;
    dat_d      = rd ? rdata : dat_q;
    gate_sel_d = gate_sel_q;
    invert_d   = invert_q;
    gatelen_d  = gatelen_q;
    enable_d   = enable_q;
    if (wr && reg_idx == 5'd0) begin
      gate_sel_d = wb_dat_i[3:0];
      invert_d   = wb_dat_i[4];
      gatelen_d  = wb_dat_i[16 +: GATELEN_WIDTH];
    end
    if (wr && reg_idx == 5'd1) enable_d = wb_dat_i[NCHAN-1:0];
    // A PPS latch wins over a coincident STATUS read clear
    new_data_d = new_data_q;
    if (pps_i) new_data_d = 1'b1;
    else if (rd && reg_idx == 5'd2) new_data_d = 1'b0;
  end

  always_comb begin
    gp_d     = gp_gate_i;
    raw_gate = 1'b0;
    if (gate_sel_q == SEL_PPS) raw_gate = win_q;
    else if (gate_sel_q == SEL_ONE) raw_gate = 1'b1;
    else begin
      for (int i = 0; i < NGP; i++) begin
        if (gate_sel_q == 4'(i + 1)) raw_gate = gp_q[i];
      end
    end
    gate_d    = raw_gate ^ invert_q;
    win_d     = 1'b0;
    win_cnt_d = '0;
    if (gate_sel_q == SEL_PPS) begin
      if (win_q) begin
        if (win_cnt_q != gatelen_q) begin
          win_d     = 1'b1;
          win_cnt_d = win_cnt_q + glen_t'(1);
        end
      end else if (pps_i) begin
        win_d = 1'b1;
      end
    end
  end

  always_comb begin
    stat_sat_d = pps_i ? sat_q : stat_sat_q;
    sat_d      = sat_q;
    for (int i = 0; i < NCHAN; i++) begin
      cnt_d[i]    = cnt_q[i];
      scaler_d[i] = scaler_q[i];
      if (pps_i) begin
        scaler_d[i] = cnt_q[i];
        cnt_d[i]    = cnt_t'(inc[i]);
        sat_d[i]    = 1'b0;
      end else if (inc[i]) begin
        if (cnt_q[i] == CNT_MAX) sat_d[i] = 1'b1;
        else cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      gate_sel_q <= '0;
      invert_q   <= 1'b0;
      gatelen_q  <= '0;
      enable_q   <= '0;
      new_data_q <= 1'b0;
      stat_sat_q <= '0;
      gp_q       <= '0;
      win_q      <= 1'b0;
      win_cnt_q  <= '0;
      gate_q     <= 1'b0;
      sat_q      <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        cnt_q[i]    <= '0;
        scaler_q[i] <= '0;
      end
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      gate_sel_q <= gate_sel_d;
      invert_q   <= invert_d;
      gatelen_q  <= gatelen_d;
      enable_q   <= enable_d;
      new_data_q <= new_data_d;
      stat_sat_q <= stat_sat_d;
      gp_q       <= gp_d;
      win_q      <= win_d;
      win_cnt_q  <= win_cnt_d;
      gate_q     <= gate_d;
      sat_q      <= sat_d;
      for (int i = 0; i < NCHAN; i++) begin
        cnt_q[i]    <= cnt_d[i];
        scaler_q[i] <= scaler_d[i];
      end
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign gate_o    = gate_q;
  assign gate_en_o = enable_q;

endmodule

// File: tb/tb_pueo_scaler_gate_counter.sv
// Directed bench for pueo_scaler_gate_counter (CNT_WIDTH=8 so one
// instance also exercises saturation).
module tb_pueo_scaler_gate_counter;

  localparam int NCHAN = 8;
  localparam int NGP   = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             cyc, stb, we;
  logic [6:0]       adr;
  logic [31:0]      wdat;
  logic [3:0]       sel;
  logic [31:0]      rdat;
  logic             ack, err, rty;
  logic             pps;
  logic [NGP-1:0]   gp;
  logic [NCHAN-1:0] trig;
  logic             gate;
  logic [NCHAN-1:0] gate_en;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pueo_scaler_gate_counter #(
    .NCHAN(NCHAN), .NGP(NGP), .CNT_WIDTH(8), .GATELEN_WIDTH(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(rdat), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty),
    .pps_i(pps), .gp_gate_i(gp), .trig_i(trig),
    .gate_o(gate), .gate_en_o(gate_en)
  );

  task automatic wb_write(input logic [6:0] a,
                          input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    total++;
    if (!ack) $display("FAIL wr_ack adr=%h got no ack want ack", a);
    else passed++;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_read(input logic [6:0] a,
                         output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    total++;
    if (!ack) $display("FAIL rd_ack adr=%h got no ack want ack", a);
    else passed++;
    d = rdat;
    cyc = 0; stb = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; cyc = 0; stb = 0; we = 0; pps = 0;
    gp = '0; trig = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic pulse_pps();
    @(negedge clk); pps = 1;
    @(negedge clk); pps = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++;
    if ({gate, gate_en, ack, err, rty} !== '0)
      $display("FAIL rst_outs got %b want 0",
               {gate, gate_en, ack, err, rty});
    else passed++;
    wb_read(7'h00, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_ctrl got %h want 0", d);
    else passed++;
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_status got %h want 0", d);
    else passed++;
    wb_read(7'h40, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_scaler0 got %h want 0", d);
    else passed++;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    do_reset();
    wb_write(7'h00, 32'hFFFF_FFFF);
    wb_read(7'h00, d);
    total++;
    if (d !== 32'hFFFF_001F)
      $display("FAIL ctrl_rb got %h want ffff001f", d);
    else passed++;
    wb_write(7'h04, 32'hFFFF_FFFF);
    wb_read(7'h04, d);
    total++;
    if (d !== 32'h0000_00FF)
      $display("FAIL enable_rb got %h want 000000ff", d);
    else passed++;
    total++;
    if (gate_en !== 8'hFF)
      $display("FAIL gate_en got %h want ff", gate_en);
    else passed++;
    wb_write(7'h08, 32'hFFFF_FFFF);
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h0) $display("FAIL status_ro got %h want 0", d);
    else passed++;
  endtask

  task automatic test_gp_gate();
    logic [31:0] d;
    do_reset();
    gp = 6'b000010;
    wb_write(7'h00, 32'h0000_0002);
    wb_write(7'h04, 32'h0000_0001);
    repeat (4) @(negedge clk);
    total++;
    if (gate !== 1'b1) $display("FAIL gp_gate got %b want 1", gate);
    else passed++;
    trig[0] = 1;
    repeat (100) @(negedge clk);
    trig[0] = 0; pps = 1;
    @(negedge clk); pps = 0;
    wb_read(7'h40, d);
    total++;
    if (d !== 32'd100) $display("FAIL gp_scaler0 got %0d want 100", d);
    else passed++;
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h8000_0000)
      $display("FAIL gp_status got %h want 80000000", d);
    else passed++;
  endtask

  task automatic test_pps_window();
    logic [31:0] d;
    int hi = 0;
    do_reset();
    wb_write(7'h04, 32'h0000_00FF);
    wb_write(7'h00, 32'h0009_0007);
    trig = '1;
    repeat (3) @(negedge clk);
    total++;
    if (gate !== 1'b0) $display("FAIL win_idle got %b want 0", gate);
    else passed++;
    @(negedge clk); pps = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); pps = 0;
      if (gate) hi++;
    end
    total++;
    if (hi != 10) $display("FAIL win_len got %0d want 10", hi);
    else passed++;
    pulse_pps();
    for (int i = 0; i < NCHAN; i++) begin
      wb_read(7'(8'h40 + 4 * i), d);
      total++;
      if (d !== 32'd10)
        $display("FAIL win_scaler%0d got %0d want 10", i, d);
      else passed++;
    end
    hi = 0;
    @(negedge clk); pps = 1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk); pps = (k == 3);
      if (gate) hi++;
    end
    pps = 0;
    total++;
    if (hi != 10) $display("FAIL win_noretrig got %0d want 10", hi);
    else passed++;
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    do_reset();
    wb_write(7'h04, 32'h0000_0008);
    wb_write(7'h00, 32'h0000_0008);
    repeat (3) @(negedge clk);
    trig[3] = 1;
    repeat (300) @(negedge clk);
    trig[3] = 0; pps = 1;
    @(negedge clk); pps = 0;
    wb_read(7'h4C, d);
    total++;
    if (d !== 32'd255) $display("FAIL sat_scaler3 got %0d want 255", d);
    else passed++;
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h8000_0008)
      $display("FAIL sat_status got %h want 80000008", d);
    else passed++;
    pulse_pps();
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h8000_0000)
      $display("FAIL sat_clear got %h want 80000000", d);
    else passed++;
    wb_read(7'h4C, d);
    total++;
    if (d !== 32'd0) $display("FAIL sat_next got %0d want 0", d);
    else passed++;
  endtask

  task automatic test_status_coincident();
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 7'h08; pps = 1;
    @(posedge clk); #1;
    pps = 0;
    total++;
    if (ack !== 1'b1 || rdat !== 32'h0)
      $display("FAIL coinc_rd got ack=%b %h want ack=1 0", ack, rdat);
    else passed++;
    cyc = 0; stb = 0;
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h8000_0000)
      $display("FAIL coinc_keep got %h want 80000000", d);
    else passed++;
    wb_read(7'h08, d);
    total++;
    if (d !== 32'h0) $display("FAIL coinc_clr got %h want 0", d);
    else passed++;
  endtask

  task automatic test_invert_unmapped_reset();
    logic [31:0] d;
    int acks = 0;
    do_reset();
    wb_write(7'h00, 32'h0000_0010);
    total++;
    if (gate !== 1'b0) $display("FAIL inv_early got %b want 0", gate);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (gate !== 1'b1) $display("FAIL inv_gate got %b want 1", gate);
    else passed++;
    d = '1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 7'h20;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++; d = rdat; cyc = 0; stb = 0;
      end
    end
    cyc = 0; stb = 0;
    total++;
    if (acks != 1 || d !== 32'h0)
      $display("FAIL unmapped got acks=%0d %h want 1 0", acks, d);
    else passed++;
    wb_write(7'h04, 32'h0000_00FF);
    wb_read(7'h00, d);
    acks = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 7'h00; rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    total++;
    if (acks != 0) $display("FAIL rst_abort got %0d acks want 0", acks);
    else passed++;
    total++;
    if ({gate, gate_en, rdat} !== '0)
      $display("FAIL rst_mid got %b %h %h want 0",
               gate, gate_en, rdat);
    else passed++;
    cyc = 0; stb = 0;
    @(negedge clk); rst = 0;
    wb_read(7'h00, d);
    total++;
    if (d !== 32'h0) $display("FAIL rst_ctrl2 got %h want 0", d);
    else passed++;
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0;
    adr = '0; wdat = '0; sel = '1;
    pps = 0; gp = '0; trig = '0;
    test_reset();
    test_regs();
    test_gp_gate();
    test_pps_window();
    test_saturate();
    test_status_coincident();
    test_invert_unmapped_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
